// File: rtl/bus_dma_initiator.sv
`default_nettype none
// ============================================================================
// bus_dma_initiator : single-channel word-copy engine, initiator on the
//                     common memory bus (read word, then write word).
// Revision          : 1.0
// ============================================================================
module bus_dma_initiator #(
    parameter int TIMEOUT   = 1024,
    parameter int LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_in,
    input  logic [31:0]          src_in,
    input  logic [31:0]          dst_in,
    input  logic [LEN_WIDTH-1:0] len_in,
    output logic                 busy_out,
    output logic                 done_out,
    output logic                 error_out,
    output logic [LEN_WIDTH-1:0] remaining_out,
    output logic [31:0]          fault_addr_out,
    output logic [31:0]          address_out,
    output logic                 read_out,
    output logic                 write_out,
    output logic [3:0]           write_mask_out,
    output logic [31:0]          write_value_out,
    input  logic [31:0]          read_value_in,
    input  logic                 ready_in,
    input  logic                 fault_in
);
    localparam int                WAIT_W    = $clog2(TIMEOUT + 2);
    localparam logic [WAIT_W-1:0] WAIT_LAST = (TIMEOUT == 0) ? '0 : WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t            state;
    logic [31:0]       src;
    logic [31:0]       dst;
    logic [31:0]       buffer;
    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

    // Bus outputs default to zero every cycle (responders OR read data onto
    // the bus); each branch re-drives them for the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            src             <= '0;
            dst             <= '0;
            buffer          <= '0;
            wait_cnt        <= '0;
            busy_out        <= 1'b0;
            done_out        <= 1'b0;
            error_out       <= 1'b0;
            remaining_out   <= '0;
            fault_addr_out  <= '0;
            address_out     <= '0;
            read_out        <= 1'b0;
            write_out       <= 1'b0;
            write_mask_out  <= '0;
            write_value_out <= '0;
        end else begin
            done_out        <= 1'b0;
            address_out     <= '0;
            read_out        <= 1'b0;
            write_out       <= 1'b0;
            write_mask_out  <= '0;
            write_value_out <= '0;
            wait_cnt        <= '0;
            case (state)
                S_IDLE: begin
                    if (start_in) begin
                        src           <= src_in;
                        dst           <= dst_in;
                        remaining_out <= len_in;
                        error_out     <= 1'b0;
                        busy_out      <= 1'b1;
                        if (src_in[1:0] != 2'b00) begin
                            state          <= S_ERROR;
                            error_out      <= 1'b1;
                            done_out       <= 1'b1;
                            fault_addr_out <= src_in;
                        end else if (dst_in[1:0] != 2'b00) begin
                            state          <= S_ERROR;
                            error_out      <= 1'b1;
                            done_out       <= 1'b1;
                            fault_addr_out <= dst_in;
                        end else if (len_in == '0) begin
                            state    <= S_DONE;
                            done_out <= 1'b1;
                        end else begin
                            state       <= S_READ;
                            address_out <= src_in;
                            read_out    <= 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (ready_in && fault_in) begin
                        state          <= S_ERROR;
                        error_out      <= 1'b1;
                        done_out       <= 1'b1;
                        fault_addr_out <= src;
                    end else if (ready_in) begin
                        state           <= S_WRITE;
                        buffer          <= read_value_in;
                        address_out     <= dst;
                        write_out       <= 1'b1;
                        write_mask_out  <= 4'b1111;
                        write_value_out <= read_value_in;
                    end else if (timeout_hit) begin
                        state          <= S_ERROR;
                        error_out      <= 1'b1;
                        done_out       <= 1'b1;
                        fault_addr_out <= src;
                    end else begin
                        wait_cnt    <= wait_cnt + 1'b1;
                        address_out <= src;
                        read_out    <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (ready_in && fault_in) begin
                        state          <= S_ERROR;
                        error_out      <= 1'b1;
                        done_out       <= 1'b1;
                        fault_addr_out <= dst;
                    end else if (ready_in) begin
                        src           <= src + 32'd4;
                        dst           <= dst + 32'd4;
                        remaining_out <= remaining_out - LEN_WIDTH'(1);
                        if (remaining_out == LEN_WIDTH'(1)) begin
                            state    <= S_DONE;
                            done_out <= 1'b1;
                        end else begin
                            state       <= S_READ;
                            address_out <= src + 32'd4;
                            read_out    <= 1'b1;
                        end
                    end else if (timeout_hit) begin
                        state          <= S_ERROR;
                        error_out      <= 1'b1;
                        done_out       <= 1'b1;
                        fault_addr_out <= dst;
                    end else begin
                        wait_cnt        <= wait_cnt + 1'b1;
                        address_out     <= dst;
                        write_out       <= 1'b1;
                        write_mask_out  <= 4'b1111;
                        write_value_out <= buffer;
                    end
                end
                S_DONE, S_ERROR: begin
                    state    <= S_IDLE;
                    busy_out <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_bus_dma_initiator.sv
`default_nettype none
// ============================================================================
// tb_bus_dma_initiator : scoreboard bench with a wait-state RAM responder and
//                        a second instance with a short timeout.
// Revision             : 1.0
// ============================================================================
module tb_bus_dma_initiator;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_in = 1'b0;
    logic        start2 = 1'b0;
    logic [31:0] src_in = '0;
    logic [31:0] dst_in = '0;
    logic [15:0] len_in = '0;

    logic        busy_out, done_out, error_out, read_out, write_out, ready_in, fault_in;
    logic [15:0] remaining_out;
    logic [31:0] fault_addr_out, address_out, write_value_out;
    logic [3:0]  write_mask_out;
    logic [31:0] read_value_in = '0;

    logic        busy2, done2, err2, rd2, wr2;
    logic [15:0] rem2;
    logic [31:0] fa2, addr2, val2;
    logic [3:0]  mask2;

    int          n_checks = 0;
    int          n_errors = 0;
    int          bus_reqs = 0;
    int          wait_states = 0;
    int          wctr = 0;
    logic [63:0] exp_q[$];
    logic [31:0] wmem [0:1023];
    bit          written [0:1023];
    logic        prev_pending = 1'b0;
    logic [95:0] prev_bus = '0;

    always #5 clk = ~clk;

    bus_dma_initiator dut (
        .clk(clk), .reset(reset), .start_in(start_in),
        .src_in(src_in), .dst_in(dst_in), .len_in(len_in),
        .busy_out(busy_out), .done_out(done_out), .error_out(error_out),
        .remaining_out(remaining_out), .fault_addr_out(fault_addr_out),
        .address_out(address_out), .read_out(read_out), .write_out(write_out),
        .write_mask_out(write_mask_out), .write_value_out(write_value_out),
        .read_value_in(read_value_in), .ready_in(ready_in), .fault_in(fault_in)
    );

    bus_dma_initiator #(.TIMEOUT(2), .LEN_WIDTH(16)) dut_to (
        .clk(clk), .reset(reset), .start_in(start2),
        .src_in(src_in), .dst_in(dst_in), .len_in(len_in),
        .busy_out(busy2), .done_out(done2), .error_out(err2),
        .remaining_out(rem2), .fault_addr_out(fa2),
        .address_out(addr2), .read_out(rd2), .write_out(wr2),
        .write_mask_out(mask2), .write_value_out(val2),
        .read_value_in(32'h0), .ready_in(1'b0), .fault_in(1'b0)
    );

    task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a >= 32'h100 && a < 32'h110)
            return 32'h11 * (((a - 32'h100) >> 2) + 32'd1);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] rdata(input logic [31:0] a);
        return written[a[11:2]] ? wmem[a[11:2]] : init_word(a);
    endfunction

    // RAM responder: mapped below 0x1000, wait_states low-ready cycles per access.
    assign ready_in = (read_out || write_out) && (wctr >= wait_states);
    assign fault_in = ready_in && (address_out >= 32'h1000);

    always @(posedge clk) begin
        if ((read_out || write_out) && !ready_in) wctr <= wctr + 1;
        else wctr <= 0;
    end

    always @(negedge clk) begin
        logic [63:0] e;
        if (read_out || write_out) bus_reqs++;
        if (prev_pending && (read_out || write_out))
            check("bus_stable", {26'b0, address_out, read_out, write_out, write_mask_out, write_value_out}, prev_bus);
        if (!read_out && !write_out)
            check("bus_idle_zero", 96'({address_out, write_mask_out, write_value_out}), 96'(0));
        if (write_out && ready_in) begin
            check("wr_expected", 96'(exp_q.size() != 0), 96'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("wr_addr", 96'(address_out), 96'(e[63:32]));
                check("wr_data", 96'(write_value_out), 96'(e[31:0]));
                check("wr_mask", 96'(write_mask_out), 96'(4'hF));
            end
            if (address_out < 32'h1000) begin
                wmem[address_out[11:2]] = write_value_out;
                written[address_out[11:2]] = 1'b1;
            end
        end
        read_value_in = (read_out && ready_in && address_out < 32'h1000) ? rdata(address_out) : 32'h0;
        prev_pending = (read_out || write_out) && !ready_in;
        prev_bus = {26'b0, address_out, read_out, write_out, write_mask_out, write_value_out};
    end

    task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({d + 32'(4 * i), rdata(s + 32'(4 * i))});
    endtask

    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n, output int cyc);
        @(negedge clk);
        start_in = 1'b1; src_in = s; dst_in = d; len_in = n;
        cyc = -1;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            start_in = 1'b0;
            if (k == 1) check("busy_after_start", 96'(busy_out), 96'(1));
            if (done_out) begin
                cyc = k;
                break;
            end
        end
        if (cyc != -1) begin
            check("busy_at_done", 96'(busy_out), 96'(1));
            @(negedge clk);
            check("done_one_cycle", 96'({busy_out, done_out}), 96'(0));
        end
    endtask

    initial begin
        int cyc;
        int reqs0;
        bit done_seen;
        #3 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", 96'({busy_out, done_out, error_out, read_out, write_out, write_mask_out}), 96'(0));
        check("rst_addr", 96'({remaining_out, fault_addr_out, address_out}), 96'(0));
        reset = 1'b1;

        // Four-word copy from preloaded RAM, zero-wait.
        exp_q.push_back({32'h200, 32'h11}); exp_q.push_back({32'h204, 32'h22});
        exp_q.push_back({32'h208, 32'h33}); exp_q.push_back({32'h20C, 32'h44});
        run(32'h100, 32'h200, 16'd4, cyc);
        check("copy4_cycles", 96'(cyc), 96'(9));
        check("copy4_err_rem", 96'({error_out, remaining_out}), 96'(0));
        for (int i = 0; i < 4; i++)
            check("copy4_ram", 96'(rdata(32'h200 + 32'(4 * i))), 96'(32'h11 * (i + 1)));
        check("copy4_queue", 96'(exp_q.size()), 96'(0));

        // Zero-length transfer: no bus traffic.
        reqs0 = bus_reqs;
        run(32'h100, 32'h200, 16'd0, cyc);
        check("len0_cycles", 96'(cyc), 96'(1));
        check("len0_no_bus", 96'(bus_reqs - reqs0), 96'(0));
        check("len0_err", 96'(error_out), 96'(0));

        // Write to unmapped destination faults on the first word.
        exp_q.push_back({32'h0004_0000, rdata(32'h10)});
        run(32'h10, 32'h0004_0000, 16'd2, cyc);
        check("wfault_cycles", 96'(cyc), 96'(3));
        check("wfault_err", 96'(error_out), 96'(1));
        check("wfault_addr", 96'(fault_addr_out), 96'(32'h0004_0000));
        check("wfault_rem", 96'(remaining_out), 96'(2));

        // Three wait states per access: 8 cycles per word.
        wait_states = 3;
        push_copy(32'h20, 32'h300, 2);
        run(32'h20, 32'h300, 16'd2, cyc);
        check("wait_cycles", 96'(cyc), 96'(17));
        check("wait_err_rem", 96'({error_out, remaining_out}), 96'(0));
        check("wait_ram", 96'(rdata(32'h304)), 96'(init_word(32'h24)));
        wait_states = 0;

        // Misaligned source / destination.
        reqs0 = bus_reqs;
        run(32'h102, 32'h200, 16'd3, cyc);
        check("msrc_cycles", 96'(cyc), 96'(1));
        check("msrc_err", 96'(error_out), 96'(1));
        check("msrc_addr", 96'(fault_addr_out), 96'(32'h102));
        check("msrc_rem", 96'(remaining_out), 96'(3));
        run(32'h100, 32'h203, 16'd1, cyc);
        check("mdst_addr", 96'({error_out, fault_addr_out}), 96'({1'b1, 32'h203}));
        check("mis_no_bus", 96'(bus_reqs - reqs0), 96'(0));
        push_copy(32'h40, 32'h400, 1);
        run(32'h40, 32'h400, 16'd1, cyc);
        check("clear_err_cycles", 96'(cyc), 96'(3));
        check("clear_err", 96'(error_out), 96'(0));

        // Reset while the second word's write is waiting.
        wait_states = 3;
        push_copy(32'h60, 32'h500, 1);
        @(negedge clk);
        start_in = 1'b1; src_in = 32'h60; dst_in = 32'h500; len_in = 16'd4;
        @(negedge clk);
        start_in = 1'b0;
        repeat (13) @(negedge clk);
        check("rst_mid_in_write", 96'({write_out, ready_in, address_out}), 96'({2'b10, 32'h504}));
        #1 reset = 1'b0;
        #1;
        check("rst_mid_ctrl", 96'({busy_out, done_out, error_out, read_out, write_out, write_mask_out}), 96'(0));
        check("rst_mid_data", 96'({remaining_out, address_out, write_value_out}), 96'(0));
        done_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done_out) done_seen = 1'b1;
        end
        check("rst_mid_no_done", 96'(done_seen), 96'(0));
        reset = 1'b1;
        check("rst_mid_queue", 96'(exp_q.size()), 96'(0));
        wait_states = 0;
        push_copy(32'h100, 32'h600, 2);
        run(32'h100, 32'h600, 16'd2, cyc);
        check("after_rst_cycles", 96'(cyc), 96'(5));
        check("after_rst_ram", 96'(rdata(32'h604)), 96'(32'h22));

        // Timeout instance: ready never rises, TIMEOUT=2.
        @(negedge clk);
        start2 = 1'b1; src_in = 32'h40; dst_in = 32'h80; len_in = 16'd3;
        @(negedge clk);
        start2 = 1'b0;
        check("to_read_req", 96'({rd2, wr2, addr2}), 96'({2'b10, 32'h40}));
        cyc = -1;
        for (int k = 2; k <= 40; k++) begin
            @(negedge clk);
            if (done2) begin
                cyc = k;
                break;
            end
        end
        check("to_cycles", 96'(cyc), 96'(3));
        check("to_err", 96'({err2, busy2, rd2}), 96'({1'b1, 1'b1, 1'b0}));
        check("to_addr", 96'(fa2), 96'(32'h40));
        check("to_rem", 96'(rem2), 96'(3));
        check("final_queue", 96'(exp_q.size()), 96'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/bus_dma_initiator.md
Name: bus_dma_initiator

Overview:
Single-channel word-copy engine that acts as an initiator on the SoC common memory bus. It drives the same address/read/write/mask/value/ready/fault protocol that the CPU bus arbiter drives toward the RAM, GPIO, timer and flash responders. A control agent programs source, destination and length, then pulses start. The engine copies the block one word at a time (read, then write) and reports done, error and progress.

Parameters:
TIMEOUT, 1024, cycles to wait for ready_in on one access before aborting with error; 0 disables the timeout.
LEN_WIDTH, 16, width of the word-count length and remaining counters.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
start_in  in  1  one-cycle start strobe
src_in  in  32  source byte address, sampled on accepted start
dst_in  in  32  destination byte address, sampled on accepted start
len_in  in  LEN_WIDTH  words to copy, sampled on accepted start
busy_out  out  1  high from accepted start until the DONE/ERROR cycle inclusive
done_out  out  1  one-cycle pulse at end of transfer (success or error)
error_out  out  1  sticky error flag, cleared on the next accepted start
remaining_out  out  LEN_WIDTH  words not yet written
fault_addr_out  out  32  address of the access that faulted or timed out
address_out  out  32  bus address
read_out  out  1  bus read request
write_out  out  1  bus write request
write_mask_out  out  4  byte write enables
write_value_out  out  32  write data
read_value_in  in  32  read data, valid when ready_in is high
ready_in  in  1  responder ready; may be high in the same cycle as the request
fault_in  in  1  unmapped-address fault, qualified by ready_in

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all outputs 0; internal address, data and count registers 0.
- States: IDLE, READ, WRITE, DONE, ERROR.
- IDLE: bus outputs all 0. This is required because responders OR their read values onto the bus.
  - start_in high: latch src, dst and len; clear error_out; busy_out=1 on the next cycle.
  - Next state: READ if len≠0; DONE if len=0 (no bus traffic).
  - If src[1:0] or dst[1:0] is nonzero: go to ERROR with fault_addr_out set to the misaligned address (src checked first); no bus traffic.
  - start_in while not IDLE: ignored.
- READ: address_out=src, read_out=1, write_out=0, write_mask_out=0, write_value_out=0. Signals are held stable until ready_in is high.
  - ready_in & ~fault_in: capture read_value_in into the data buffer; go to WRITE.
  - ready_in & fault_in: go to ERROR; fault_addr_out=src.
- WRITE: address_out=dst, write_out=1, read_out=0, write_mask_out=4'b1111, write_value_out=buffer. Signals are held until ready_in is high.
  - ready_in & ~fault_in: src+=4 and dst+=4 (modulo 2^32, 0xFFFFFFFC wraps to 0); remaining-=1.
  - If remaining becomes 0: go to DONE. Otherwise go to READ.
  - ready_in & fault_in: go to ERROR; fault_addr_out=dst.
- Timeout: a wait counter resets on every state entry and increments each cycle in READ/WRITE while ready_in is low. Reaching TIMEOUT aborts to ERROR with fault_addr_out=current address_out.
- DONE: bus outputs 0; done_out=1 for one cycle; busy_out=1; next state IDLE.
- ERROR: bus outputs 0; error_out=1 (sticky); done_out=1 for one cycle; remaining_out frozen; next state IDLE.
- Latency with a zero-wait responder: start accepted at cycle 0, READ at cycle 1, WRITE at cycle 2, i.e. 2 cycles per word. N words gives done_out at cycle 2N+1.
- remaining_out = len on accept; decrements on each completed write only.
- Reset mid-transfer: aborts immediately to IDLE with outputs 0; no done_out pulse.

Test Plan:
- src=0x100, dst=0x200, len=4, RAM preloaded 0x11,0x22,0x33,0x44, zero-wait bus -> RAM[0x200..0x20C]=0x11..0x44; done_out at cycle 9; error_out=0; remaining_out=0.
- len=0 start -> done_out next cycle+1; read_out/write_out never asserted; error_out=0.
- src=0x10, dst=0x00040000 (unmapped), len=2 -> first write faults; error_out=1; fault_addr_out=0x00040000; remaining_out=2; done_out pulse.
- Responder holds ready_in low 3 cycles per access -> bus signals stable throughout; data correct; 8 cycles/word. With TIMEOUT=2, abort with error_out=1 and fault_addr_out=src.
- src=0x102 -> immediate ERROR; fault_addr_out=0x102; no bus activity. Next valid start clears error_out.
- Assert reset low during WRITE of word 2 of 4 -> all outputs 0 asynchronously; no done_out; new start after release works normally.
